// File: rtl/if_id_latch_pkg.sv
// Shared pipeline definitions: bubble encoding, HALT opcode and IF/ID state encoding.
package if_id_latch_pkg;

   localparam logic [15:0] IFID_NOP_INSTR = 16'h0800;
   localparam logic [4:0]  IFID_HALT_OPC  = 5'b00000;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } ifid_state_t;

   function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] opc);
      return (instr[15:11] == opc);
   endfunction

endpackage

// File: rtl/dff.sv
// Basic D flip-flop cell with synchronous active-high reset to a parameterized value.
module dff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_q <= RST_VAL;
      else       r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg16_en.sv
// 16-bit register built from the dff cell; loads i_d when i_en, otherwise holds.
module reg16_en #(
   parameter logic [15:0] RST_VAL = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [15:0] i_d,
   output logic [15:0] o_q
);

   logic [15:0] w_q;
   logic [15:0] w_d;

   assign w_d = i_en ? i_d : w_q;

   dff #(.W(16), .RST_VAL(RST_VAL)) u_dff (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (w_d),
      .o_q   (w_q)
   );

   assign o_q = w_q;

endmodule

// File: rtl/if_id_latch.sv
// IF/ID pipeline latch: captures fetch output, inserts bubbles on flush/exception,
// holds on stall, counts stalled cycles and freezes after latching a HALT.
module if_id_latch
   import if_id_latch_pkg::*;
#(
   parameter logic [15:0] NOP_INSTR = IFID_NOP_INSTR,
   parameter logic [4:0]  HALT_OPC  = IFID_HALT_OPC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] InstrIn,
   input  logic [15:0] IncPCIn,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Exception,
   output logic [15:0] InstrOut,
   output logic [15:0] IncPCOut,
   output logic        ValidOut,
   output logic        HaltOut,
   output logic [15:0] StallCount
);

   logic        w_state_bit;
   ifid_state_t w_state;
   ifid_state_t w_state_d;
   logic        w_run;
   logic        w_squash;
   logic        w_capture;
   logic        w_load;
   logic [15:0] w_instr_d;
   logic [15:0] w_instr_q;
   logic [15:0] w_pc_q;
   logic        w_valid_d;
   logic        w_valid_q;
   logic        w_sc_en;
   logic [15:0] w_sc_q;

   assign w_state   = ifid_state_t'(w_state_bit);
   assign w_run     = (w_state == ST_RUN);
   assign w_squash  = Flush | Exception;
   assign w_capture = w_run & ~w_squash & ~Stall;
   // A squash also loads the data registers (bubble + fresh PC), so it overrides Stall.
   assign w_load    = w_run & (w_squash | ~Stall);

   assign w_instr_d = w_squash ? NOP_INSTR : InstrIn;
   assign w_valid_d = w_load ? ~w_squash : w_valid_q;
   assign w_sc_en   = w_run & ~w_squash & Stall & (w_sc_q != 16'hFFFF);
   assign w_state_d = (w_capture & is_halt(InstrIn, HALT_OPC)) ? ST_HALTED : w_state;

   dff #(.W(1), .RST_VAL(1'(ST_RUN))) u_state (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (w_state_d),
      .o_q   (w_state_bit)
   );

   dff #(.W(1), .RST_VAL(1'b0)) u_valid (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (w_valid_d),
      .o_q   (w_valid_q)
   );

   reg16_en #(.RST_VAL(NOP_INSTR)) u_instr (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_load),
      .i_d   (w_instr_d),
      .o_q   (w_instr_q)
   );

   reg16_en #(.RST_VAL(16'h0000)) u_pc (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_load),
      .i_d   (IncPCIn),
      .o_q   (w_pc_q)
   );

   reg16_en #(.RST_VAL(16'h0000)) u_stall_cnt (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_sc_en),
      .i_d   (w_sc_q + 16'd1),
      .o_q   (w_sc_q)
   );

   assign InstrOut   = w_instr_q;
   assign IncPCOut   = w_pc_q;
   assign ValidOut   = w_valid_q;
   assign HaltOut    = (w_state == ST_HALTED);
   assign StallCount = w_sc_q;

endmodule

// File: tb/tb_if_id_latch.sv
// Randomized and directed bench for if_id_latch against a behavioural model of the latch.
module tb_if_id_latch;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] InstrIn;
   logic [15:0] IncPCIn;
   logic        Stall;
   logic        Flush;
   logic        Exception;
   logic [15:0] InstrOut;
   logic [15:0] IncPCOut;
   logic        ValidOut;
   logic        HaltOut;
   logic [15:0] StallCount;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // behavioural model state
   logic [15:0] m_instr;
   logic [15:0] m_pc;
   logic        m_valid;
   logic        m_halt;
   int          m_sc;

   if_id_latch dut (
      .clk        (clk),
      .rst        (rst),
      .InstrIn    (InstrIn),
      .IncPCIn    (IncPCIn),
      .Stall      (Stall),
      .Flush      (Flush),
      .Exception  (Exception),
      .InstrOut   (InstrOut),
      .IncPCOut   (IncPCOut),
      .ValidOut   (ValidOut),
      .HaltOut    (HaltOut),
      .StallCount (StallCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: apply inputs, advance the model by the latch's rules, settle past the edge.
   task automatic cycle(input logic r, input logic s, input logic f, input logic e,
                        input logic [15:0] ins, input logic [15:0] pc);
      rst = r; Stall = s; Flush = f; Exception = e; InstrIn = ins; IncPCIn = pc;
      @(posedge clk);
      if (r) begin
         m_instr = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0; m_halt = 1'b0; m_sc = 0;
      end else if (!m_halt) begin
         if (f || e) begin
            m_instr = 16'h0800; m_pc = pc; m_valid = 1'b0;
         end else if (s) begin
            m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
         end else begin
            m_instr = ins; m_pc = pc; m_valid = 1'b1;
            if (ins[15:11] == 5'b00000) m_halt = 1'b1;
         end
      end
      chk_en = 1'b1;
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("InstrOut",   InstrOut,        m_instr);
         chk("IncPCOut",   IncPCOut,        m_pc);
         chk("ValidOut",   16'(ValidOut),   16'(m_valid));
         chk("HaltOut",    16'(HaltOut),    16'(m_halt));
         chk("StallCount", StallCount,      16'(m_sc));
      end
   end

   initial begin
      rst = 1'b1; Stall = 1'b0; Flush = 1'b0; Exception = 1'b0;
      InstrIn = 16'h4021; IncPCIn = 16'h0002;

      // reset, then first capture
      cycle(1, 0, 0, 0, 16'h4021, 16'h0002);
      cycle(1, 0, 0, 0, 16'h4021, 16'h0002);
      chk("rst_instr", InstrOut, 16'h0800);
      chk("rst_pc",    IncPCOut, 16'h0000);
      chk("rst_valid", 16'(ValidOut), 16'h0);
      chk("rst_halt",  16'(HaltOut),  16'h0);
      chk("rst_sc",    StallCount, 16'h0000);
      cycle(0, 0, 0, 0, 16'h4021, 16'h0002);
      chk("cap_instr", InstrOut, 16'h4021);
      chk("cap_pc",    IncPCOut, 16'h0002);
      chk("cap_valid", 16'(ValidOut), 16'h1);

      // three stalled cycles with changing fetch data
      cycle(0, 1, 0, 0, 16'h5555, 16'h0004);
      cycle(0, 1, 0, 0, 16'h6666, 16'h0006);
      cycle(0, 1, 0, 0, 16'h7777, 16'h0008);
      chk("stall_instr", InstrOut, 16'h4021);
      chk("stall_pc",    IncPCOut, 16'h0002);
      chk("stall_cnt",   StallCount, 16'h0003);
      cycle(0, 0, 0, 0, 16'h1234, 16'h0004);
      chk("release_instr", InstrOut, 16'h1234);

      // flush beats stall
      cycle(0, 1, 1, 0, 16'hC123, 16'h0006);
      chk("fs_instr", InstrOut, 16'h0800);
      chk("fs_pc",    IncPCOut, 16'h0006);
      chk("fs_valid", 16'(ValidOut), 16'h0);
      chk("fs_sc",    StallCount, 16'h0003);

      // squashed HALT does not halt; back-to-back bubbles
      cycle(0, 0, 0, 1, 16'h0000, 16'h0008);
      chk("exc_instr", InstrOut, 16'h0800);
      chk("exc_halt",  16'(HaltOut), 16'h0);
      cycle(0, 0, 1, 0, 16'h2222, 16'h000A);
      cycle(0, 0, 1, 0, 16'h3333, 16'h000C);
      chk("bb_valid", 16'(ValidOut), 16'h0);
      chk("bb_pc",    IncPCOut, 16'h000C);

      // HALT freezes everything until reset
      cycle(0, 0, 0, 0, 16'h0000, 16'h0010);
      chk("halt_set", 16'(HaltOut), 16'h1);
      for (int i = 0; i < 5; i++)
         cycle(0, 1'(i % 2), 1'(i == 1), 1'(i == 3), 16'h9000 + 16'(i), 16'h0100 + 16'(i));
      chk("halted_instr", InstrOut, 16'h0000);
      chk("halted_pc",    IncPCOut, 16'h0010);
      chk("halted_sc",    StallCount, 16'h0003);
      cycle(1, 0, 0, 0, 16'h0000, 16'h0000);
      chk("halt_clr", 16'(HaltOut), 16'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         if ($urandom_range(0, 15) == 0) ins[15:11] = 5'b00000;
         cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
               ins, 16'($urandom));
      end

      // stall counter saturation
      cycle(1, 0, 0, 0, 16'h4021, 16'h0002);
      cycle(0, 0, 0, 0, 16'h4021, 16'h0002);
      for (int i = 0; i < 65540; i++) cycle(0, 1, 0, 0, 16'(i), 16'(i));
      chk("sat_cnt", StallCount, 16'hFFFF);
      cycle(0, 1, 0, 0, 16'hAAAA, 16'h0000);
      chk("sat_hold", StallCount, 16'hFFFF);
      cycle(0, 1, 1, 0, 16'hAAAA, 16'h0000);
      chk("sat_flush", StallCount, 16'hFFFF);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_latch.md
IF_ID_LATCH -- requirements
Module: if_id_latch

Interface
REQ-001 The block SHALL have the parameter NOP_INSTR, default 16'h0800, the encoding of the bubble inserted into decode.
REQ-002 The block SHALL have the parameter HALT_OPC, default 5'b00000, the opcode (Instr[15:11]) that identifies HALT.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 InstrIn  input  16  instruction word from fetch.
REQ-006 IncPCIn  input  16  PC+2 from fetch.
REQ-007 Stall  input  1  hazard stall from decode; hold the current contents.
REQ-008 Flush  input  1  branch/jump taken; squash the instruction in fetch.
REQ-009 Exception  input  1  exception raised; squash the instruction in fetch.
REQ-010 InstrOut  output  16  registered instruction to decode.
REQ-011 IncPCOut  output  16  registered PC+2 to decode.
REQ-012 ValidOut  output  1  InstrOut is a real instruction and not a bubble.
REQ-013 HaltOut  output  1  a HALT has been latched and the state is HALTED.
REQ-014 StallCount  output  16  saturating count of stalled cycles since reset.

Function
REQ-015 State machine: two states, RUN and HALTED; the state is registered.
REQ-016 Per-cycle priority in RUN: rst > (Flush | Exception) > Stall > capture.
REQ-017 Flush or Exception (either one or both): next InstrOut=NOP_INSTR, IncPCOut=IncPCIn, ValidOut=0; the flush wins over a simultaneous Stall.
REQ-018 Stall without flush: InstrOut, IncPCOut and ValidOut hold their values; StallCount increments by 1 and saturates at 16'hFFFF.
REQ-019 Capture (no flush, no stall): next InstrOut=InstrIn, IncPCOut=IncPCIn, ValidOut=1.
REQ-020 RUN->HALTED occurs on the edge that captures an InstrIn with InstrIn[15:11]==HALT_OPC; HaltOut=1 from that edge onward.
REQ-021 A HALT that is squashed by a flush or blocked by a stall SHALL NOT cause the transition.
REQ-022 HALTED: all registers hold; Stall, Flush and Exception are ignored; StallCount does not increment; the only exit is rst.
REQ-023 Latency is exactly one cycle from InstrIn/IncPCIn to the outputs; there is no combinational path from any input to any output.
REQ-024 IncPCOut is captured unmodified; no arithmetic is applied.
REQ-025 Back-to-back flushes produce consecutive bubbles, one per flushed cycle.
REQ-026 ValidOut=0 with HaltOut=0 SHALL be the only bubble indication; decode treats it as a no-op.

Reset
REQ-027 On a clock edge with rst=1: InstrOut=NOP_INSTR, IncPCOut=16'h0000, ValidOut=0, HaltOut=0, StallCount=0, state=RUN.
REQ-028 rst overrides every other input in every state, including mid-stall and HALTED.
REQ-029 The first capture occurs on the first edge with rst=0 and no Stall, Flush or Exception.

Structure
REQ-030 NOP_INSTR, the HALT opcode and the state encodings SHALL live in the shared definitions file used by the pipeline stages.
REQ-031 Storage SHALL be built from the codebase's dff cell.
REQ-032 One sub-module, reg16_en, SHALL provide a 16-bit dff register with a load enable and a load value; it is instantiated for InstrOut, IncPCOut and StallCount.
REQ-033 The next-state and next-value muxing SHALL be written as continuous assigns in the top module.

Verification
REQ-034 rst=1 for 2 cycles, then InstrIn=16'h4021, IncPCIn=16'h0002 -> after reset, outputs 0x0800/0x0000/valid 0; one cycle later 0x4021/0x0002/valid 1.
REQ-035 Stall=1 for 3 cycles while InstrIn changes -> outputs frozen; StallCount=3; on release the next InstrIn is captured.
REQ-036 Flush=1 and Stall=1 in the same cycle, InstrIn=16'hC123 -> InstrOut=0x0800, ValidOut=0, StallCount unchanged.
REQ-037 InstrIn=16'h0000 captured -> HaltOut=1; then Flush, Exception and new instructions for 5 cycles -> outputs unchanged; rst -> HaltOut=0.
REQ-038 InstrIn=16'h0000 with Exception=1 -> no halt; InstrOut=0x0800; the state remains RUN.
REQ-039 StallCount preloaded near the limit by holding Stall for 65540 cycles -> StallCount=16'hFFFF and stays there.
